// File: rtl/ycr_mem_share.sv
// Round-robin share of one memory port between imem (port 0) and dmem (port 1),
// with an owner-ID FIFO steering in-order responses back. Optional response timeout: YCR_MEM_SHARE_TMO_EN.
module ycr_mem_share #(
   parameter int DEPTH      = 4,
   parameter int TMO_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        p0_req,
   output logic        p0_req_ack,
   input  logic        p0_cmd,
   input  logic [1:0]  p0_width,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic [31:0] p0_rdata,
   output logic [1:0]  p0_resp,
   input  logic        p1_req,
   output logic        p1_req_ack,
   input  logic        p1_cmd,
   input  logic [1:0]  p1_width,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic [31:0] p1_rdata,
   output logic [1:0]  p1_resp,
   output logic        m_req,
   input  logic        m_req_ack,
   output logic        m_cmd,
   output logic [1:0]  m_width,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_resp,
   output logic        err_unexp
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DEPTH-1:0] fifo_id;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             rr_ptr, lock, lock_id;
   logic             gnt_vld, gnt_id, gnt_req;
   logic             full, empty, accept, head_id;
   logic             resp_vld, tmo_hit, pop;
   logic [1:0]       rt_resp;
   logic [31:0]      rt_rdata;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head_id = fifo_id[rd_ptr];

   // A pending unacked request freezes the grant so the m_* fields stay stable.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (lock) begin
         gnt_vld = 1'b1;
         gnt_id  = lock_id;
      end else if (p0_req && p1_req) begin
         gnt_vld = 1'b1;
         gnt_id  = rr_ptr;
      end else if (p0_req) begin
         gnt_vld = 1'b1;
      end else if (p1_req) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   assign gnt_req    = gnt_id ? p1_req : p0_req;
   assign m_req      = gnt_vld & gnt_req & ~full;
   assign m_cmd      = gnt_id ? p1_cmd   : p0_cmd;
   assign m_width    = gnt_id ? p1_width : p0_width;
   assign m_addr     = gnt_id ? p1_addr  : p0_addr;
   assign m_wdata    = gnt_id ? p1_wdata : p0_wdata;
   assign accept     = m_req & m_req_ack;
   assign p0_req_ack = accept & ~gnt_id;
   assign p1_req_ack = accept &  gnt_id;

   assign resp_vld = (m_resp != 2'b00) & ~empty;

`ifdef YCR_MEM_SHARE_TMO_EN
   localparam int TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = ~empty & (tmo_cnt == TW'(TMO_CYCLES));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)             tmo_cnt <= '0;
      else if (empty || pop) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + TW'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // A real response in the same cycle as a timeout takes priority.
   assign pop      = resp_vld | tmo_hit;
   assign rt_resp  = resp_vld ? m_resp  : 2'b10;
   assign rt_rdata = resp_vld ? m_rdata : 32'h0;

   always_comb begin
      p0_resp  = 2'b00;
      p1_resp  = 2'b00;
      p0_rdata = 32'h0;
      p1_rdata = 32'h0;
      if (pop) begin
         if (head_id) begin
            p1_resp  = rt_resp;
            p1_rdata = rt_rdata;
         end else begin
            p0_resp  = rt_resp;
            p0_rdata = rt_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo_id   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rr_ptr    <= 1'b0;
         lock      <= 1'b0;
         lock_id   <= 1'b0;
         err_unexp <= 1'b0;
      end else begin
         if (accept) begin
            fifo_id[wr_ptr] <= gnt_id;
            wr_ptr          <= wr_ptr + PTR_ONE;
            rr_ptr          <= ~gnt_id;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (accept && !pop)      count <= count + CNT_ONE;
         else if (!accept && pop) count <= count - CNT_ONE;
         if (accept) begin
            lock <= 1'b0;
         end else if (m_req && !m_req_ack) begin
            lock    <= 1'b1;
            lock_id <= gnt_id;
         end
         if ((m_resp != 2'b00) && empty) err_unexp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ycr_mem_share.sv
// Self-checking bench for ycr_mem_share: vector table, scoreboarded contention run, lock/reset/timeout sequences.
module tb_ycr_mem_share;

   logic        clk = 1'b0;
   logic        rstn;
   logic        p0_req, p1_req, p0_req_ack, p1_req_ack;
   logic        p0_cmd, p1_cmd;
   logic [1:0]  p0_width, p1_width, p0_resp, p1_resp;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic        m_req, m_req_ack, m_cmd;
   logic [1:0]  m_width, m_resp;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        err_unexp;

   int n_pass = 0;
   int n_tot  = 0;

   ycr_mem_share #(.DEPTH(4), .TMO_CYCLES(8)) dut (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p0_req_ack(p0_req_ack), .p0_cmd(p0_cmd), .p0_width(p0_width),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_resp(p0_resp),
      .p1_req(p1_req), .p1_req_ack(p1_req_ack), .p1_cmd(p1_cmd), .p1_width(p1_width),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_resp(p1_resp),
      .m_req(m_req), .m_req_ack(m_req_ack), .m_cmd(m_cmd), .m_width(m_width),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp),
      .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        p0r, p1r, ack;
      logic [1:0]  mresp;
      logic [31:0] mrdata;
      logic        e_mreq, e_a0, e_a1;
      logic [31:0] e_addr;
      logic [1:0]  e_r0, e_r1;
      logic [31:0] e_d0, e_d1;
      logic        e_err;
   } vec_t;

   vec_t vt[15];

   typedef struct {
      logic        port;
      logic [31:0] data;
   } sb_t;

   sb_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic drv(input logic r0, input logic r1, input logic ack,
                      input logic [1:0] rsp, input logic [31:0] rd);
      p0_req = r0; p1_req = r1; m_req_ack = ack; m_resp = rsp; m_rdata = rd;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drv(0, 0, 0, 2'b00, 32'h0);
      rstn = 1'b0;
      #3;
      chk("rst_m_req", m_req, 0);
      chk("rst_acks", {p0_req_ack, p1_req_ack}, 0);
      chk("rst_resp", {p0_resp, p1_resp}, 0);
      chk("rst_rdata", p0_rdata | p1_rdata, 0);
      chk("rst_err", err_unexp, 0);
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      logic        rr_m;
      logic        found;
      int          hit_k;
      sb_t         e;

      p0_cmd = 1'b0; p1_cmd = 1'b1;
      p0_width = 2'b10; p1_width = 2'b00;
      p0_addr = 32'h100; p1_addr = 32'h200;
      p0_wdata = 32'hA0; p1_wdata = 32'hB1;
      rstn = 1'b1;
      drv(0, 0, 0, 2'b00, 32'h0);

      //        p0r p1r ack rsp    rdata         mreq a0 a1  addr      r0     r1     d0            d1     err
      vt[0]  = '{0, 0, 0, 2'b00, 32'h0,        0, 0, 0, 32'h100, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[1]  = '{1, 0, 1, 2'b00, 32'h0,        1, 1, 0, 32'h100, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[2]  = '{0, 0, 0, 2'b01, 32'hDEADBEEF, 0, 0, 0, 32'h100, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0, 0};
      vt[3]  = '{1, 1, 1, 2'b00, 32'h0,        1, 0, 1, 32'h200, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[4]  = '{1, 1, 1, 2'b00, 32'h0,        1, 1, 0, 32'h100, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[5]  = '{1, 1, 1, 2'b00, 32'h0,        1, 0, 1, 32'h200, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[6]  = '{1, 1, 1, 2'b00, 32'h0,        1, 1, 0, 32'h100, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[7]  = '{1, 1, 1, 2'b00, 32'h0,        0, 0, 0, 32'h200, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[8]  = '{1, 1, 1, 2'b01, 32'h1,        0, 0, 0, 32'h200, 2'b00, 2'b01, 32'h0,        32'h1, 0};
      vt[9]  = '{1, 1, 1, 2'b01, 32'h2,        1, 0, 1, 32'h200, 2'b01, 2'b00, 32'h2,        32'h0, 0};
      vt[10] = '{0, 0, 0, 2'b01, 32'h3,        0, 0, 0, 32'h100, 2'b00, 2'b01, 32'h0,        32'h3, 0};
      vt[11] = '{0, 0, 0, 2'b01, 32'h4,        0, 0, 0, 32'h100, 2'b01, 2'b00, 32'h4,        32'h0, 0};
      vt[12] = '{0, 0, 0, 2'b10, 32'h5,        0, 0, 0, 32'h100, 2'b00, 2'b10, 32'h0,        32'h5, 0};
      vt[13] = '{0, 0, 0, 2'b01, 32'h6,        0, 0, 0, 32'h100, 2'b00, 2'b00, 32'h0,        32'h0, 0};
      vt[14] = '{0, 0, 0, 2'b00, 32'h0,        0, 0, 0, 32'h100, 2'b00, 2'b00, 32'h0,        32'h0, 1};

      do_reset();
      for (int i = 0; i < 15; i++) begin
         drv(vt[i].p0r, vt[i].p1r, vt[i].ack, vt[i].mresp, vt[i].mrdata);
         #3;
         chk($sformatf("v%0d_m_req", i), m_req, vt[i].e_mreq);
         chk($sformatf("v%0d_acks", i), {p0_req_ack, p1_req_ack}, {vt[i].e_a0, vt[i].e_a1});
         chk($sformatf("v%0d_m_addr", i), m_addr, vt[i].e_addr);
         chk($sformatf("v%0d_m_wdata", i), m_wdata, (vt[i].e_addr == 32'h200) ? 32'hB1 : 32'hA0);
         chk($sformatf("v%0d_m_cmd_w", i), {m_cmd, m_width},
             (vt[i].e_addr == 32'h200) ? 3'b100 : 3'b010);
         chk($sformatf("v%0d_resp", i), {p0_resp, p1_resp}, {vt[i].e_r0, vt[i].e_r1});
         chk($sformatf("v%0d_rdata0", i), p0_rdata, vt[i].e_d0);
         chk($sformatf("v%0d_rdata1", i), p1_rdata, vt[i].e_d1);
         chk($sformatf("v%0d_err", i), err_unexp, vt[i].e_err);
         tick();
      end
      repeat (3) tick();
      chk("err_sticky", err_unexp, 1);

      // Contention: alternate grants, responses must come back in issue order.
      do_reset();
      rr_m = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(1, 1, 1, 2'b00, 32'h0);
         #3;
         chk($sformatf("rr%0d_acks", i), {p0_req_ack, p1_req_ack}, rr_m ? 2'b01 : 2'b10);
         e.port = rr_m;
         e.data = $urandom;
         sb_q.push_back(e);
         rr_m = ~rr_m;
         tick();
      end
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         drv(0, 0, 0, 2'b01, e.data);
         #3;
         if (e.port) begin
            chk("sb_p1_resp", {p0_resp, p1_resp}, 4'b0001);
            chk("sb_p1_rdata", p1_rdata, e.data);
         end else begin
            chk("sb_p0_resp", {p0_resp, p1_resp}, 4'b0100);
            chk("sb_p0_rdata", p0_rdata, e.data);
         end
         tick();
      end
      drv(0, 0, 0, 2'b00, 32'h0);
      #3;
      chk("sb_no_err", err_unexp, 0);
      tick();

      // Lock: p1 waits unacked; p0 arriving with rr favouring it must not steal the grant.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drv(i >= 1, 1, 0, 2'b00, 32'h0);
         #3;
         chk($sformatf("lock%0d_addr", i), m_addr, 32'h200);
         chk($sformatf("lock%0d_mreq", i), m_req, 1);
         chk($sformatf("lock%0d_acks", i), {p0_req_ack, p1_req_ack}, 2'b00);
         tick();
      end
      drv(1, 1, 1, 2'b00, 32'h0);
      #3;
      chk("lock_ack_p1", {p0_req_ack, p1_req_ack}, 2'b01);
      tick();
      #3;
      chk("lock_then_p0", {p0_req_ack, p1_req_ack}, 2'b10);
      tick();

      // Reset mid-stream discards outstanding entries; late response is unexpected.
      do_reset();
      drv(1, 0, 1, 2'b00, 32'h0);
      tick();
      do_reset();
      drv(0, 0, 0, 2'b01, 32'h55);
      #3;
      chk("late_resp_dropped", {p0_resp, p1_resp}, 4'b0000);
      tick();
      drv(0, 0, 0, 2'b00, 32'h0);
      #3;
      chk("late_resp_err", err_unexp, 1);
      tick();

      // Missing response: timeout path when enabled, indefinite stall otherwise.
      do_reset();
      drv(1, 0, 1, 2'b00, 32'h0);
      #3;
      chk("tmo_accept", p0_req_ack, 1);
      tick();
      drv(0, 0, 0, 2'b00, 32'h0);
      found = 1'b0;
      hit_k = 0;
`ifdef YCR_MEM_SHARE_TMO_EN
      for (int k = 1; k <= 30 && !found; k++) begin
         #3;
         if (p0_resp == 2'b10) begin
            found = 1'b1;
            hit_k = k;
            chk("tmo_rdata", p0_rdata, 0);
            chk("tmo_p1_idle", p1_resp, 2'b00);
         end
         tick();
      end
      chk("tmo_seen", found, 1);
      chk("tmo_cycle", hit_k, 9);
      drv(0, 0, 0, 2'b01, 32'h77);
      #3;
      chk("tmo_fifo_empty", p0_resp, 2'b00);
      tick();
      drv(0, 0, 0, 2'b00, 32'h0);
      #3;
      chk("tmo_then_err", err_unexp, 1);
`else
      for (int k = 1; k <= 30; k++) begin
         #3;
         if (p0_resp != 2'b00) found = 1'b1;
         tick();
      end
      chk("no_tmo_stall", found, 0);
      drv(0, 0, 0, 2'b01, 32'h77);
      #3;
      chk("stall_resp", p0_resp, 2'b01);
      chk("stall_rdata", p0_rdata, 32'h77);
      tick();
      drv(0, 0, 0, 2'b00, 32'h0);
      #3;
      chk("stall_no_err", err_unexp, 0);
`endif
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/ycr_mem_share.md
Name: ycr_mem_share

Overview:
- Shares one core memory port between two requesters (port 0 = imem, port 1 = dmem) using round-robin arbitration.
- Tracks outstanding transactions in an owner-ID FIFO so in-order memory responses are steered back to the issuing port.
- Sits between the core's memory request ports and the single TCM/AXI-bridge port.
- Supports pipelined requests: a new request may be accepted before earlier responses return.

Parameters:
- DEPTH, 4, maximum outstanding transactions; power of two, at least 2.
- TMO_CYCLES, 255, response timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- p0_req / p1_req  input  1  port request
- p0_req_ack / p1_req_ack  output  1  request accepted this cycle
- p0_cmd / p1_cmd  input  1  0 = read, 1 = write
- p0_width / p1_width  input  2  00 = byte, 01 = half, 10 = word
- p0_addr / p1_addr  input  32  address
- p0_wdata / p1_wdata  input  32  write data
- p0_rdata / p1_rdata  output  32  read data
- p0_resp / p1_resp  output  2  00 = idle, 01 = ok, 10 = error
- m_req  output  1  memory request
- m_req_ack  input  1  memory accepted request
- m_cmd  output  1  muxed cmd
- m_width  output  2  muxed width
- m_addr  output  32  muxed addr
- m_wdata  output  32  muxed wdata
- m_rdata  input  32  memory read data
- m_resp  input  2  memory response, same encoding as pX_resp
- err_unexp  output  1  sticky flag: response arrived with no outstanding transaction

Behaviour:
- Reset values:
  - State: rr_ptr = 0 (port 0 favoured), lock = 0, FIFO count = 0.
  - Outputs: m_req = 0, pX_req_ack = 0, pX_resp = 00, pX_rdata = 0, err_unexp = 0.
- Grant selection, when not locked:
  - Only one port requesting: grant that port.
  - Both requesting: grant the port equal to rr_ptr.
  - Neither requesting: no grant, m_req = 0.
- Lock:
  - Set when m_req = 1 and m_req_ack = 0.
  - While set, the grant is frozen on lock_id, so the m_* fields stay stable until the ack.
  - Cleared on acceptance.
- Memory request:
  - m_req = granted pX_req AND FIFO not full.
  - m_cmd, m_width, m_addr and m_wdata are muxed combinationally from the granted port.
  - When no port is granted, the m_* fields take port 0 values.
- Acceptance (m_req & m_req_ack):
  - pX_req_ack = 1 for the granted port only, combinationally in the same cycle.
  - Granted ID is pushed into the FIFO.
  - rr_ptr <= ~granted ID.
  - Zero added latency; one request accepted per cycle maximum.
- FIFO full (count == DEPTH):
  - m_req forced 0 and no acks are issued.
  - A request whose m_req was already raised and is unacked keeps its lock; m_req drops until space frees.
- Response routing (m_resp != 00 with FIFO non-empty):
  - Head ID selects the port: pHead_resp = m_resp and pHead_rdata = m_rdata, combinationally in the same cycle.
  - FIFO pops.
  - The other port sees resp 00.
- Unexpected response (m_resp != 00 with FIFO empty): ignored and err_unexp <= 1; err_unexp clears only on reset.
- Simultaneous push and pop: count unchanged; pointers advance modulo DEPTH and wrap naturally.
- A push while full cannot occur because m_req is gated.
- Reset mid-transaction: all outstanding entries are discarded and late memory responses then set err_unexp.

Optional Feature:
- Macro: YCR_MEM_SHARE_TMO_EN.
- With the macro defined:
  - A counter runs while FIFO count > 0; it clears to 0 on every pop, or when the FIFO is empty.
  - When it reaches TMO_CYCLES, the head owner receives resp = 10 and rdata = 0 for one cycle, the head is popped and the counter restarts.
  - If m_resp arrives in the same cycle, the real response wins.
- Without the macro: no counter is present and a missing response stalls routing indefinitely.

Test Plan:
- Single requester: p0_req with addr 0x100, read, m_req_ack = 1 in the same cycle -> p0_req_ack = 1, FIFO count 1; then m_resp = 01 with rdata 0xDEADBEEF -> p0_resp = 01, p0_rdata = 0xDEADBEEF, p1_resp = 00.
- Contention: p0 and p1 both requesting continuously with m_req_ack = 1 -> grants 0,1,0,1; then responses 01 x4 -> routed to p0,p1,p0,p1 in that order.
- Lock: p1 requests while m_req_ack = 0 for 3 cycles and p0 raises its request in cycle 2 -> m_addr stays p1_addr throughout and the ack goes to p1 first.
- Full: DEPTH = 4, four acks with no responses -> m_req = 0 and no pX_req_ack on a 5th request; one response pops -> the 5th request is accepted the next cycle.
- Unexpected response: m_resp = 01 after reset with no requests -> err_unexp = 1, persistent; a mid-stream rstn pulse -> count 0 and all outputs return to reset values.
- With YCR_MEM_SHARE_TMO_EN and TMO_CYCLES = 8: one accepted read and no response -> the owner gets resp = 10 after the counter reaches 8 cycles; FIFO empty after.
